// File: rtl/mbist_march_ctrl.sv
// March C- BIST engine driving a memory with a 2-cycle read latency and registered wdata.
// Define MBIST_CHECKERBOARD_EN to append a second pass with a checkerboard background.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [3:0]            fail_element,
  output logic [FAIL_CNT_W-1:0] fail_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam int PIPE = 4;

`ifdef MBIST_CHECKERBOARD_EN
  function automatic logic [DATA_WIDTH-1:0] checker_pattern();
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < DATA_WIDTH; i++) p[i] = ~i[0];
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] CHECKER = checker_pattern();
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [2:0]              elem;
  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic                    phase;
  logic [1:0]              drain_cnt;
  logic                    cb_pass;

  logic                    last_pass;
  logic                    down;
  logic                    addr_end;
  logic                    last_of_addr;
  logic                    start_accept;
  logic [DATA_WIDTH-1:0]   bg;
  logic                    op_we;
  logic                    op_rd;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_data;
  logic [DATA_WIDTH-1:0]   op_exp;

  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [PIPE-1:0]         pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_exp  [PIPE];
  logic [ADDR_WIDTH-1:0]   pipe_addr [PIPE];
  logic [3:0]              pipe_elem [PIPE];
  logic                    mismatch;

`ifdef MBIST_CHECKERBOARD_EN
  assign last_pass = cb_pass;
  assign bg        = !cb_pass ? '0 : (addr_cnt[0] ? ~CHECKER : CHECKER);
`else
  assign last_pass = 1'b1;
  assign bg        = '0;
`endif

  assign down         = (elem == 3'd3) || (elem == 3'd4);
  assign addr_end     = down ? (addr_cnt == '0) : (addr_cnt == LAST_ADDR);
  assign last_of_addr = (elem == 3'd0) || (elem == 3'd5) || phase;
  assign start_accept = start && ((state == IDLE) || (state == DONE));

  // Elements 1..4 pair a read of one background with a write of its inverse.
  always_comb begin
    op_we   = 1'b0;
    op_rd   = 1'b0;
    op_addr = '0;
    op_data = '0;
    op_exp  = '0;
    if (state == RUN) begin
      op_addr = addr_cnt;
      op_we   = (elem == 3'd0) || ((elem != 3'd5) && phase);
      op_rd   = !op_we;
      if (op_we) op_data = ((elem == 3'd1) || (elem == 3'd3)) ? ~bg : bg;
      op_exp  = ((elem == 3'd2) || (elem == 3'd4)) ? ~bg : bg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      elem      <= '0;
      addr_cnt  <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
      cb_pass   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            elem     <= '0;
            addr_cnt <= '0;
            phase    <= 1'b0;
            cb_pass  <= 1'b0;
          end
        end
        RUN: begin
          if (!last_of_addr) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!addr_end) begin
              addr_cnt <= down ? addr_cnt - ADDR_WIDTH'(1) : addr_cnt + ADDR_WIDTH'(1);
            end else if (elem != 3'd5) begin
              elem     <= elem + 3'd1;
              addr_cnt <= ((elem == 3'd2) || (elem == 3'd3)) ? LAST_ADDR : '0;
            end else if (!last_pass) begin
              cb_pass  <= 1'b1;
              elem     <= '0;
              addr_cnt <= '0;
            end else begin
              state     <= DRAIN;
              drain_cnt <= '0;
              elem      <= '0;
              addr_cnt  <= '0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // wdata leads the command by one cycle; expected data trails to the rdata return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wdata      <= '0;
      cmd_we         <= 1'b0;
      cmd_addr       <= '0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      pipe_valid     <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_exp[i]  <= '0;
        pipe_addr[i] <= '0;
        pipe_elem[i] <= '0;
      end
    end else begin
      mem_wdata      <= op_data;
      cmd_we         <= op_we;
      cmd_addr       <= op_addr;
      mem_write_read <= cmd_we;
      mem_address    <= cmd_addr;
      pipe_valid     <= {pipe_valid[PIPE-2:0], op_rd};
      pipe_exp[0]    <= op_exp;
      pipe_addr[0]   <= op_addr;
      pipe_elem[0]   <= {cb_pass, elem};
      for (int i = 1; i < PIPE; i++) begin
        pipe_exp[i]  <= pipe_exp[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_elem[i] <= pipe_elem[i-1];
      end
    end
  end

  assign mismatch = pipe_valid[PIPE-1] && (mem_rdata != pipe_exp[PIPE-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail         <= 1'b0;
      fail_count   <= '0;
      fail_addr    <= '0;
      fail_element <= '0;
    end else if (start_accept) begin
      fail         <= 1'b0;
      fail_count   <= '0;
      fail_addr    <= '0;
      fail_element <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (fail_count != '1) fail_count <= fail_count + FAIL_CNT_W'(1);
      if (!fail) begin
        fail_addr    <= pipe_addr[PIPE-1];
        fail_element <= pipe_elem[PIPE-1];
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural memory with injectable faults, a March C-
// reference model, directed vector table, random fault runs and multi-cycle sequences.
`timescale 1ns/1ps
module tb_mbist_march_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int CAP   = 15;
  localparam int WORDS = CAP + 1;
`ifdef MBIST_CHECKERBOARD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int NOPS     = 10 * WORDS * PASSES;
  localparam int DONE_CYC = NOPS + 5;

  typedef struct {
    bit          all_addr;
    int          addr;
    logic [DW-1:0] sa1;
    logic [DW-1:0] sa0;
    bit          ps;
    logic [DW-1:0] trig;
  } fault_t;

  typedef struct {
    bit          we;
    int          addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    string  name;
    fault_t f;
    bit     e_fail;
    int     e_addr;
    int     e_elem;
    int     e_count;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [3:0]    fail_element;
  logic [7:0]    fail_count;
  logic          mem_write_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          sat_busy, sat_done, sat_fail;
  logic [AW-1:0] sat_fail_addr;
  logic [3:0]    sat_fail_element;
  logic [1:0]    sat_fail_count;
  logic          sat_mem_write_read;
  logic [AW-1:0] sat_mem_address;
  logic [DW-1:0] sat_mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  fault_t        flt;
  logic [DW-1:0] mem [WORDS];
  logic [DW-1:0] wreg, rd1, rd2;

  op_t  exp_ops[$];
  bit   exp_fail;
  int   exp_addr;
  int   exp_elem;
  int   exp_count;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .FAIL_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_element(fail_element), .fail_count(fail_count),
    .mem_write_read(mem_write_read), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Narrow counter twin; it sees the same command stream, so it shares the memory model.
  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .FAIL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(sat_busy), .done(sat_done), .fail(sat_fail),
    .fail_addr(sat_fail_addr), .fail_element(sat_fail_element), .fail_count(sat_fail_count),
    .mem_write_read(sat_mem_write_read), .mem_address(sat_mem_address), .mem_wdata(sat_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] read_fault(input fault_t f, input int a,
                                               input logic [DW-1:0] v, input logic [DW-1:0] nb);
    logic [DW-1:0] r;
    r = v;
    if (f.all_addr || a == f.addr) r = (r | f.sa1) & ~f.sa0;
    if (f.ps && a == f.addr && nb == f.trig) r = r ^ DW'(1);
    return r;
  endfunction

  // Memory: wdata captured a cycle ahead of the write; reads return two cycles later.
  always @(posedge clk) begin
    wreg <= mem_wdata;
    rd1  <= read_fault(flt, int'(mem_address), mem[mem_address], mem[(int'(mem_address) + 1) % WORDS]);
    rd2  <= rd1;
    if (mem_write_read) mem[mem_address] <= wreg;
  end
  assign mem_rdata = rd2;

  function automatic logic [DW-1:0] bg_of(input int p, input int a);
    logic [DW-1:0] cb;
    for (int i = 0; i < DW; i++) cb[i] = (i % 2 == 0);
    if (p == 0) return '0;
    return (a % 2 == 0) ? cb : ~cb;
  endfunction

  function automatic fault_t mk_fault(input bit all_addr, input int addr, input logic [DW-1:0] sa1,
                                      input logic [DW-1:0] sa0, input bit ps, input logic [DW-1:0] trig);
    fault_t f;
    f.all_addr = all_addr; f.addr = addr; f.sa1 = sa1; f.sa0 = sa0; f.ps = ps; f.trig = trig;
    return f;
  endfunction

  task automatic build_model(input fault_t f);
    logic [DW-1:0] mm [WORDS];
    op_t           o;
    int            a;
    logic [DW-1:0] d, want, got;
    exp_ops.delete();
    exp_fail = 0; exp_addr = 0; exp_elem = 0; exp_count = 0;
    for (int i = 0; i < WORDS; i++) mm[i] = '0;
    for (int p = 0; p < PASSES; p++) begin
      for (int e = 0; e < 6; e++) begin
        for (int i = 0; i < WORDS; i++) begin
          a = (e == 3 || e == 4) ? CAP - i : i;
          d = bg_of(p, a);
          if (e != 0) begin
            want = (e == 2 || e == 4) ? ~d : d;
            o.we = 1'b0; o.addr = a; o.data = '0;
            exp_ops.push_back(o);
            got = read_fault(f, a, mm[a], mm[(a + 1) % WORDS]);
            if (got != want) begin
              if (!exp_fail) begin
                exp_addr = a;
                exp_elem = p * 8 + e;
              end
              exp_fail = 1;
              exp_count++;
            end
          end
          if (e != 5) begin
            o.we = 1'b1; o.addr = a; o.data = (e == 1 || e == 3) ? ~d : d;
            exp_ops.push_back(o);
            mm[a] = o.data;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic trace_run(output int done_at, output int trace_err);
    done_at = -1;
    trace_err = 0;
    for (int k = 1; k <= DONE_CYC + 20; k++) begin
      @(negedge clk);
      if (done) begin
        done_at = k;
        break;
      end
      if (busy !== 1'b1) trace_err++;
      if (k >= 3 && k - 2 <= NOPS) begin
        if (mem_write_read !== exp_ops[k-3].we || int'(mem_address) != exp_ops[k-3].addr) trace_err++;
      end
      if (k >= 2 && k - 1 <= NOPS) begin
        if (exp_ops[k-2].we && mem_wdata !== exp_ops[k-2].data) trace_err++;
      end
    end
  endtask

  task automatic applyStimulus(input bit hold, output int done_at, output int trace_err);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    trace_run(done_at, trace_err);
    start = 1'b0;
  endtask

  task automatic check_results(input string name, input bit ef, input int ea, input int ee,
                               input int ec, input int done_at, input int trace_err);
    checkOutput({name, ".done_cycle"}, done_at, DONE_CYC);
    checkOutput({name, ".cmd_trace_errs"}, trace_err, 0);
    checkOutput({name, ".fail"}, fail, ef);
    checkOutput({name, ".fail_addr"}, fail_addr, ea);
    checkOutput({name, ".fail_element"}, fail_element, ee);
    checkOutput({name, ".fail_count"}, fail_count, (ec > 255) ? 255 : ec);
    checkOutput({name, ".idle_cmd_busy"}, {busy, mem_write_read, mem_address, mem_wdata}, 0);
    checkOutput({name, ".sat_fail_count"}, sat_fail_count, (ec > 3) ? 3 : ec);
    checkOutput({name, ".sat_diag"}, {sat_fail, sat_fail_addr, sat_fail_element}, {ef, 4'(ea), 4'(ee)});
    checkOutput({name, ".sat_idle"},
                {sat_busy, ~sat_done, sat_mem_write_read, sat_mem_address, sat_mem_wdata}, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit hold);
    int done_at, trace_err;
    flt = v.f;
    build_model(v.f);
    applyStimulus(hold, done_at, trace_err);
    check_results(v.name, v.e_fail, v.e_addr, v.e_elem, v.e_count, done_at, trace_err);
  endtask

  task automatic add_vec(input string name, input fault_t f, input bit ef, input int ea,
                         input int ee, input int ec);
    vec_t v;
    v.name = name; v.f = f; v.e_fail = ef; v.e_addr = ea; v.e_elem = ee; v.e_count = ec;
    vecs.push_back(v);
  endtask

  initial begin
    int     done_at, trace_err;
    fault_t clean, f;
    vec_t   v;

    clean = mk_fault(0, 0, '0, '0, 0, '0);
    add_vec("clean",     clean,                                   0, 0, 0, 0);
    add_vec("sa1_a5_b3", mk_fault(0, 5, 8'h08, '0, 0, '0),        1, 5, 1, (PASSES == 2) ? 5 : 3);
    add_vec("all_sa1",   mk_fault(1, 0, 8'hFF, '0, 0, '0),        1, 0, 1, (PASSES == 2) ? 128 : 48);
    add_vec("sa0_a0_b0", mk_fault(0, 0, '0, 8'h01, 0, '0),        1, 0, 2, (PASSES == 2) ? 5 : 2);
    add_vec("ps_met",    mk_fault(0, 7, '0, '0, 1, 8'hFF),        1, 7, 2, 2);
    add_vec("ps_never",  mk_fault(0, 7, '0, '0, 1, 8'hA5),        0, 0, 0, 0);

    flt = clean;
    repeat (3) @(negedge clk);
    checkOutput("reset.outputs",
                {busy, done, fail, fail_addr, fail_element, fail_count,
                 mem_write_read, mem_address, mem_wdata}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle.no_start", {busy, done, mem_write_read, mem_address, mem_wdata}, 0);

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // Randomised faults checked against the reference model.
    for (int r = 0; r < 8; r++) begin
      f = mk_fault($urandom_range(3, 0) == 0, int'($urandom_range(CAP, 0)),
                   DW'($urandom) & DW'($urandom), '0, $urandom_range(1, 0) == 1,
                   ($urandom_range(1, 0) == 1) ? 8'hFF : DW'($urandom));
      f.sa0 = DW'($urandom) & DW'($urandom) & ~f.sa1;
      if ($urandom_range(3, 0) == 0) begin
        f.sa1 = '0;
        f.sa0 = '0;
      end
      build_model(f);
      v.name = $sformatf("rand%0d", r);
      v.f = f; v.e_fail = exp_fail; v.e_addr = exp_addr; v.e_elem = exp_elem; v.e_count = exp_count;
      run_vec(v, $urandom_range(1, 0) == 1);
    end

    // Start held through the run and into DONE: one test, then a clean restart.
    flt = mk_fault(0, 5, 8'h08, '0, 0, '0);
    build_model(flt);
    applyStimulus(1'b1, done_at, trace_err);
    checkOutput("hold.done_cycle", done_at, DONE_CYC);
    checkOutput("hold.cmd_trace_errs", trace_err, 0);
    checkOutput("hold.fail", fail, 1);
    start = 1'b1;
    flt = clean;
    build_model(flt);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("restart.busy_done", {busy, done}, 2'b10);
    checkOutput("restart.cleared", {fail, fail_count, fail_addr, fail_element}, 0);
    trace_run(done_at, trace_err);
    check_results("restart", 0, 0, 0, 0, done_at, trace_err);

    // Asynchronous reset in cycle 50 of a faulty run.
    flt = mk_fault(0, 5, 8'h08, '0, 0, '0);
    build_model(flt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 50; k++) @(negedge clk);
    checkOutput("midrst.fail_before", {busy, fail}, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.outputs",
                {busy, done, fail, fail_addr, fail_element, fail_count,
                 mem_write_read, mem_address, mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v.name = "after_rst"; v.f = clean; v.e_fail = 0; v.e_addr = 0; v.e_elem = 0; v.e_count = 0;
    run_vec(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- March C- BIST engine that sits directly upstream of fault_mem. Drives the memory's write_read, address and wdata pins and checks the memory's rdata.
- Generates the full March C- sequence over addresses 0..CAPACITY, compares every read against its expected background, and reports pass/fail plus first-failure diagnostics.
- Runs the memory at one operation per clock. The data-to-command skew and read latency are aligned internally.

Parameters:
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 4, memory address width
- CAPACITY, 15, highest valid address; the test covers CAPACITY+1 words
- FAIL_CNT_W, 8, width of the saturating failure counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level/pulse; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done rises
- done  output  1  high after the sequence completes; held until the next accepted start
- fail  output  1  sticky; high once any read mismatches
- fail_addr  output  ADDR_WIDTH  address of first mismatch
- fail_element  output  4  bit3 = pass (0 solid, 1 checkerboard); bits2:0 = March element 0..5 of first mismatch
- fail_count  output  FAIL_CNT_W  mismatching reads, saturates at all-ones
- mem_write_read  output  1  1 = write, 0 = read; connects to memory write_read
- mem_address  output  ADDR_WIDTH  connects to memory address
- mem_wdata  output  DATA_WIDTH  connects to memory wdata
- mem_rdata  input  DATA_WIDTH  from memory rdata

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset values: all outputs 0 (busy, done, fail, fail_addr, fail_element, fail_count, mem_write_read, mem_address, mem_wdata).
- Reset asserted mid-run aborts immediately and returns to IDLE. No partial results are kept.

Memory timing contract (fixed):
- The memory registers wdata one cycle before it uses it.
- Read data appears on mem_rdata 2 cycles after the read command is on mem_address/mem_write_read.

Command pipeline:
- The op generator produces an op (we, addr, data, expected, element) in cycle t.
- mem_wdata is registered, so it is visible in cycle t+1.
- mem_write_read and mem_address are registered twice, so they are visible in cycle t+2.
- Compare stage samples mem_rdata at the end of cycle t+4. Expected data, address and element travel through a matching 4-stage delay with a valid bit.

March C- elements, D = background:
- 0: ⇕ w D
- 1: ⇑ r D, w ~D
- 2: ⇑ r ~D, w D
- 3: ⇓ r D, w ~D
- 4: ⇓ r ~D, w D
- 5: ⇕ r D
- ⇑ means address 0..CAPACITY; ⇓ means CAPACITY..0.
- Each ops are issued back-to-back: for every address, its read is followed by its write in the next cycle.
- Total ops per pass: 10*(CAPACITY+1).
- Solid background D = all zeros.

FSM:
- IDLE: start=1 -> RUN; clears fail, fail_count, fail_addr, fail_element and done.
- RUN: one op per cycle. Address counter wraps at element boundaries (up: CAPACITY->0, down: 0->CAPACITY), then element increments. After the last op of element 5 of the final pass -> DRAIN.
- DRAIN: 4 cycles, so the pipeline empties and outstanding compares complete. Then -> DONE.
- DONE: done=1, busy=0. start=1 -> RUN, restarting a fresh test.
- start is ignored while busy.
- When no op is active (IDLE/DRAIN/DONE), the command outputs are read, address 0, wdata 0.

Compare and diagnostics:
- A mismatch is a read whose mem_rdata differs from expected in any bit.
- On a mismatch: fail<=1 and fail_count increments (saturating).
- fail_addr/fail_element are captured only on the first mismatch.
- A mismatch on the final compare, coincident with the entry to DONE, is still counted before done rises.

Optional Feature:
- Macro: MBIST_CHECKERBOARD_EN.
- Defined: after the solid pass, a second full March C- pass runs with a checkerboard background. D = 0x55-pattern (alternating 01 bits, width-extended) for even addresses and its inverse for odd addresses. This pass uses fail_element bit3=1 and gives 20*(CAPACITY+1) ops total.
- Undefined: solid pass only; fail_element bit3 is tied 0.

Test Plan:
- Fault-free memory, defaults, start pulsed at edge E0: first op in cycle 1; done rises in cycle 165 (325 with MBIST_CHECKERBOARD_EN); fail=0; fail_count=0.
- Memory model with addr 5 bit 3 stuck-at-1, solid pass: fail=1, fail_addr=5, fail_element=4'h1, fail_count=3 (mismatches in elements 1, 3, 5).
- fault_mem with its pattern-sensitive fault enabled at its fault address and neighbourhood condition met: fail=1, fail_addr equals that address. Separately, an arrangement with the condition never met gives fail=0.
- rst_n driven low in cycle 50 of a run: all outputs 0 in that same cycle (asynchronous). Restart after release completes with done in 165 cycles.
- start held high for the whole run: exactly one test executes. In DONE, start held high restarts the test; fail/fail_count are cleared on restart.
- fail_count saturation with FAIL_CNT_W=2 and an all-bits-stuck memory: fail_count stops at 3.
